hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It decodes the instruction words held in the D, E and M pipeline registers and detects read-after-write hazards that forwarding cannot cover, using Tuse/Tnew rules. On a hazard it freezes PC and IF/ID and bubbles ID/EX. It also owns the mult/div busy counter and blocks HI/LO instructions in D while the MD unit is busy.

Parameters:
MULT_CYCLES, 5, busy cycles after mult/multu leaves E
DIV_CYCLES, 10, busy cycles after div/divu leaves E
CNT_W, 4, busy counter width; must hold DIV_CYCLES

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
IR_D  input  32  instruction in ID stage
IR_E  input  32  instruction in EX stage
IR_M  input  32  instruction in MEM stage
stall  output  1  hold PC and IF/ID
flush_E  output  1  load nop (0) into ID/EX next edge; equals stall
md_start  output  1  pulse to MD unit: IR_E is mult/multu/div/divu
md_busy  output  1  MD unit computing (cnt != 0)

Behaviour:
- Single clock Clk. Reset is synchronous and active-high.
- Decode classes by opcode[31:26] / funct[5:0]:
  - load: 0x20, 0x21, 0x23, 0x24, 0x25
  - store: 0x28, 0x29, 0x2B
  - cal_i: 0x09, 0x0A, 0x0C, 0x0D, 0x0F
  - branch: 0x04, 0x05
  - jal: 0x03
  - op=0 with funct 0x08 is jr; 0x09 is jalr
  - md: funct 0x18/0x19/0x1A/0x1B
  - mf: funct 0x10/0x12
  - mt: funct 0x11/0x13
  - any other op=0 instruction is cal_r
  - anything else is treated as nop.
- Write register A3:
  - cal_r, mf, jalr: rd
  - cal_i, load: rt
  - jal: 31
  - otherwise: 0
- Tuse_rs:
  - 0 for branch, jr, jalr
  - 1 for cal_r, cal_i, load, store, md, mt
  - otherwise infinite (no use)
- Tuse_rt:
  - 0 for branch
  - 1 for cal_r, md
  - 2 for store
  - otherwise infinite
- Tnew_E:
  - load = 2
  - cal_r, cal_i, mf = 1
  - jal, jalr = 0
- Tnew_M:
  - load = 1
  - otherwise 0
- Register hazard stall: for src in {rs, rt} of IR_D, stall if src != 0 and either
  - src == A3_E and Tnew_E > Tuse_src, or
  - src == A3_M and Tnew_M > Tuse_src.
- MD stall: IR_D is md, mf or mt and (md_start or md_busy).
- stall = register hazard OR MD stall. It is purely combinational, same cycle. flush_E = stall.
- Busy counter cnt[CNT_W-1:0], updated at posedge Clk:
  - Reset: cnt <= 0.
  - Else if md_start: cnt <= MULT_CYCLES for funct 0x18/0x19, DIV_CYCLES for 0x1A/0x1B.
  - Else if cnt != 0: cnt <= cnt - 1.
  - Otherwise hold.
- md_start is combinational from IR_E, so it is high for exactly one cycle per MD instruction.
- md_busy = (cnt != 0).
- Latency: mult in E at cycle t gives md_start at t, md_busy over t+1..t+5, and cnt = 0 at t+6. An mflo in D is stalled over t..t+5 and advances at t+6.
- A new md_start while md_busy cannot occur, because D is stalled. If it ever does, the counter reloads (md_start has priority).
- Reset values: cnt = 0 and md_busy = 0. With IRs at 0 (nop after pipeline reset), stall = flush_E = md_start = 0.
- Reset mid-count clears cnt at that edge. md_busy is 0 in the following cycle.
- No internal state besides cnt. Stall decisions never depend on a previous stall.

Test Plan:
1. IR_E=0x8C010000 (lw $1), IR_D=0x00231021 (addu $2,$1,$3) -> stall=flush_E=1. Next cycle IR_E=0, IR_M=0x8C010000 -> stall=0 (Tnew_M=1, Tuse=1).
2. IR_E=0x00430821 (addu $1), IR_D=0x10220000 (beq $1,$2) -> stall=1. Same beq with IR_M=0x8C010000 (lw $1 in M) -> stall=1. With IR_M=addu $1 -> stall=0.
3. IR_E=0x8C010000, IR_D=0xAC010000 (sw $1) -> stall=0 (Tuse_rt=2, Tnew_E=2). IR_E=0x8C000000 (lw $0), IR_D=0x00031021 -> stall=0.
4. IR_E=0x00850018 (mult) at cycle t, then IR_E=0, IR_D=0x00003012 (mflo $6) held -> md_start=1 at t only, md_busy=1 over t+1..t+5, stall=1 over t..t+5, stall=0 at t+6.
5. IR_E=0x0085001A (div) -> md_busy for exactly 10 cycles. Assert Reset at 3rd busy cycle -> md_busy=0 on the next cycle, stall drops with mflo in D.
6. Reset with arbitrary IRs=0 -> all outputs 0. Random instruction streams are checked against a Tuse/Tnew reference model, with no stall when both sources are $0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Decodes IR_D/IR_E/IR_M, applies Tuse/Tnew rules for RAW hazards that
// forwarding cannot resolve, and tracks the mult/div busy window.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        stall,
  output logic        flush_E,
  output logic        md_start,
  output logic        md_busy
);

  localparam logic [3:0] C_NOP   = 4'd0;
  localparam logic [3:0] C_LOAD  = 4'd1;
  localparam logic [3:0] C_STORE = 4'd2;
  localparam logic [3:0] C_CALI  = 4'd3;
  localparam logic [3:0] C_BR    = 4'd4;
  localparam logic [3:0] C_JAL   = 4'd5;
  localparam logic [3:0] C_JR    = 4'd6;
  localparam logic [3:0] C_JALR  = 4'd7;
  localparam logic [3:0] C_MD    = 4'd8;
  localparam logic [3:0] C_MF    = 4'd9;
  localparam logic [3:0] C_MT    = 4'd10;
  localparam logic [3:0] C_CALR  = 4'd11;

  // Tuse of 3 means "never read"; Tnew never exceeds 2, so it can't stall.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  function automatic logic [3:0] cls_of(input logic [31:0] ir);
    logic [3:0] c;
    c = C_NOP;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h08:                      c = C_JR;
          6'h09:                      c = C_JALR;
          6'h18, 6'h19, 6'h1A, 6'h1B: c = C_MD;
          6'h10, 6'h12:               c = C_MF;
          6'h11, 6'h13:               c = C_MT;
          default:                    c = C_CALR;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_LOAD;
      6'h28, 6'h29, 6'h2B:               c = C_STORE;
      6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: c = C_CALI;
      6'h04, 6'h05:                      c = C_BR;
      6'h03:                             c = C_JAL;
      default:                           c = C_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] a3_of(input logic [3:0] c, input logic [31:0] ir);
    logic [4:0] a;
    a = 5'd0;
    case (c)
      C_CALR, C_MF, C_JALR: a = ir[15:11];
      C_CALI, C_LOAD:       a = ir[20:16];
      C_JAL:                a = 5'd31;
      default:              a = 5'd0;
    endcase
    return a;
  endfunction

  function automatic logic [1:0] tnew_e_of(input logic [3:0] c);
    logic [1:0] t;
    t = 2'd0;
    case (c)
      C_LOAD:               t = 2'd2;
      C_CALR, C_CALI, C_MF: t = 2'd1;
      default:              t = 2'd0;
    endcase
    return t;
  endfunction

  logic [3:0]       cls_d, cls_e, cls_m;
  logic [4:0]       rs_d, rt_d, a3_e, a3_m;
  logic [1:0]       tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic             hz_rs, hz_rt, md_stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage decode and Tuse/Tnew lookup.
  always_comb begin
    cls_d  = cls_of(IR_D);
    cls_e  = cls_of(IR_E);
    cls_m  = cls_of(IR_M);
    rs_d   = IR_D[25:21];
    rt_d   = IR_D[20:16];
    a3_e   = a3_of(cls_e, IR_E);
    a3_m   = a3_of(cls_m, IR_M);
    tnew_e = tnew_e_of(cls_e);
    tnew_m = (cls_m == C_LOAD) ? 2'd1 : 2'd0;
    case (cls_d)
      C_BR, C_JR, C_JALR:                              tuse_rs = 2'd0;
      C_CALR, C_CALI, C_LOAD, C_STORE, C_MD, C_MT:     tuse_rs = 2'd1;
      default:                                         tuse_rs = TUSE_NONE;
    endcase
    case (cls_d)
      C_BR:         tuse_rt = 2'd0;
      C_CALR, C_MD: tuse_rt = 2'd1;
      C_STORE:      tuse_rt = 2'd2;
      default:      tuse_rt = TUSE_NONE;
    endcase
  end

  // Stall when a source's producer won't have its result ready by Tuse.
  always_comb begin
    hz_rs    = (rs_d != 5'd0) &&
               (((rs_d == a3_e) && (tnew_e > tuse_rs)) ||
                ((rs_d == a3_m) && (tnew_m > tuse_rs)));
    hz_rt    = (rt_d != 5'd0) &&
               (((rt_d == a3_e) && (tnew_e > tuse_rt)) ||
                ((rt_d == a3_m) && (tnew_m > tuse_rt)));
    md_start = (cls_e == C_MD);
    md_busy  = (cnt_q != '0);
    md_stall = ((cls_d == C_MD) || (cls_d == C_MF) || (cls_d == C_MT)) &&
               (md_start || md_busy);
    stall    = hz_rs || hz_rt || md_stall;
    flush_E  = stall;
  end

  // Busy counter next state; a new start reloads even if still counting.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start)
      cnt_d = IR_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Busy counter register.
  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl plus a short randomized
// register-hazard sweep against an independent Tuse/Tnew reference.
module tb_hazard_stall_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        stall, flush_E, md_start, md_busy;

  int nvec = 0;
  int nerr = 0;

  hazard_stall_ctrl dut (
    .Clk(Clk), .Reset(Reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .stall(stall), .flush_E(flush_E), .md_start(md_start), .md_busy(md_busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic s, input logic st, input logic bz);
    #1;
    chk({tag, ".stall"},    stall,    s);
    chk({tag, ".flush_E"},  flush_E,  s);
    chk({tag, ".md_start"}, md_start, st);
    chk({tag, ".md_busy"},  md_busy,  bz);
  endtask

  // ---- reference model (register hazards only) ----
  function automatic int ref_a3(input logic [31:0] ir);
    logic [5:0] op, fn;
    op = ir[31:26]; fn = ir[5:0];
    if (op == 6'h03) return 31;
    if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25 ||
        op == 6'h09 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0F)
      return int'(ir[20:16]);
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h11 || fn == 6'h13 || (fn >= 6'h18 && fn <= 6'h1B)) return 0;
      return int'(ir[15:11]);
    end
    return 0;
  endfunction

  function automatic bit ref_is_load(input logic [31:0] ir);
    return ir[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic int ref_tnew_e(input logic [31:0] ir);
    if (ref_is_load(ir)) return 2;
    if (ir[31:26] inside {6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) return 1;
    if (ir[31:26] == 6'h00 && !(ir[5:0] inside {6'h08, 6'h09, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B}))
      return 1;
    return 0;
  endfunction

  // which: 0 = rs, 1 = rt; 9 stands for "never used"
  function automatic int ref_tuse(input logic [31:0] ir, input int which);
    logic [5:0] op, fn;
    op = ir[31:26]; fn = ir[5:0];
    if (op == 6'h04 || op == 6'h05) return 0;
    if (op inside {6'h28, 6'h29, 6'h2B}) return (which == 0) ? 1 : 2;
    if (ref_is_load(ir) || op inside {6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F}) return (which == 0) ? 1 : 9;
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h09) return (which == 0) ? 0 : 9;
      if (fn == 6'h10 || fn == 6'h12) return 9;
      if (fn == 6'h11 || fn == 6'h13) return (which == 0) ? 1 : 9;
      return 1;
    end
    return 9;
  endfunction

  function automatic bit ref_stall(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    bit s;
    int src, tu;
    s = 0;
    for (int w = 0; w < 2; w++) begin
      src = (w == 0) ? int'(d[25:21]) : int'(d[20:16]);
      tu  = ref_tuse(d, w);
      if (src != 0) begin
        if (src == ref_a3(e) && ref_tnew_e(e) > tu) s = 1;
        if (src == ref_a3(m) && (ref_is_load(m) ? 1 : 0) > tu) s = 1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] mk(input int k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    case (k)
      0: return {6'h23, rs, rt, 16'h0004};
      1: return {6'h2B, rs, rt, 16'h0008};
      2: return {6'h0D, rs, rt, 16'h00FF};
      3: return {6'h00, rs, rt, rd, 5'h0, 6'h21};
      4: return {6'h04, rs, rt, 16'h0010};
      5: return {6'h03, 26'h0000100};
      6: return {6'h00, rs, 15'h0, 6'h08};
      7: return {6'h00, rs, 5'h0, rd, 5'h0, 6'h09};
      default: return {6'h0F, 5'h0, rt, 16'h1234};
    endcase
  endfunction

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  initial begin
    Reset = 1'b1; IR_D = '0; IR_E = '0; IR_M = '0;
    tick(); tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    // 1: lw in E feeding addu in D, then lw moves to M.
    tick();
    IR_E = 32'h8C010000; IR_D = 32'h00231021; IR_M = '0;
    chk_all("lw_E_addu", 1'b1, 1'b0, 1'b0);
    tick();
    IR_E = '0; IR_M = 32'h8C010000;
    chk_all("lw_M_addu", 1'b0, 1'b0, 1'b0);

    // 2: beq consumes at Tuse=0.
    tick();
    IR_D = 32'h10220000; IR_E = 32'h00430821; IR_M = '0;
    chk_all("addu_E_beq", 1'b1, 1'b0, 1'b0);
    tick();
    IR_E = '0; IR_M = 32'h8C010000;
    chk_all("lw_M_beq", 1'b1, 1'b0, 1'b0);
    tick();
    IR_M = 32'h00430821;
    chk_all("addu_M_beq", 1'b0, 1'b0, 1'b0);

    // 3: store data forwarded late; writes to $0 never hazard.
    tick();
    IR_E = 32'h8C010000; IR_D = 32'hAC010000; IR_M = '0;
    chk_all("lw_E_sw", 1'b0, 1'b0, 1'b0);
    tick();
    IR_E = 32'h8C000000; IR_D = 32'h00031021;
    chk_all("lw0_E", 1'b0, 1'b0, 1'b0);

    // 4: mult then mflo held in D.
    tick();
    IR_E = 32'h00850018; IR_D = 32'h00003012; IR_M = '0;
    chk_all("mult_t0", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      IR_E = '0;
      chk_all($sformatf("mult_t%0d", k), 1'b1, 1'b0, 1'b1);
    end
    tick();
    chk_all("mult_t6", 1'b0, 1'b0, 1'b0);

    // 5a: div busy for exactly 10 cycles.
    tick();
    IR_E = 32'h0085001A; IR_D = 32'h00003012;
    chk_all("div_t0", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      IR_E = '0;
      chk_all($sformatf("div_t%0d", k), 1'b1, 1'b0, 1'b1);
    end
    tick();
    chk_all("div_t11", 1'b0, 1'b0, 1'b0);

    // 5b: div, reset on 3rd busy cycle.
    tick();
    IR_E = 32'h0085001B;
    chk_all("divr_t0", 1'b1, 1'b1, 1'b0);
    tick(); IR_E = '0;
    chk_all("divr_t1", 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("divr_t2", 1'b1, 1'b0, 1'b1);
    tick(); Reset = 1'b1;
    chk_all("divr_t3", 1'b1, 1'b0, 1'b1);
    tick(); Reset = 1'b0;
    chk_all("divr_t4", 1'b0, 1'b0, 1'b0);

    // 6: reset with zero IRs, then random register-hazard sweep.
    Reset = 1'b1; IR_D = '0; IR_E = '0; IR_M = '0;
    tick();
    chk_all("reset2", 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      tick();
      IR_D = mk($urandom_range(0, 8), rreg(), rreg(), rreg());
      IR_E = mk($urandom_range(0, 8), rreg(), rreg(), rreg());
      IR_M = mk($urandom_range(0, 8), rreg(), rreg(), rreg());
      #1;
      chk($sformatf("rnd%0d", n), {stall, flush_E, md_start, md_busy},
          {ref_stall(IR_D, IR_E, IR_M), ref_stall(IR_D, IR_E, IR_M), 2'b00});
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      IR_D = mk($urandom_range(0, 8), 5'd0, 5'd0, rreg());
      IR_E = mk(n % 9, 5'd0, 5'd0, 5'd0);
      IR_M = mk(0, 5'd0, 5'd0, 5'd0);
      #1;
      chk($sformatf("zero_src%0d", n), stall, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
